multi_sel_seq: RTL and testbench
================================

MULTI_SEL_SEQ -- requirements
Module: multi_sel_seq

Interface
REQ-001 SHALL have parameter DW, default 8, input sample width.
REQ-002 SHALL have parameter N, default 4, steps per sample (N >= 2).
REQ-003 SHALL have parameter CW, default 4, coefficient width; OW = DW+CW is derived, not a parameter.
REQ-004 SHALL have parameter COEF_INIT, default {4'd7,4'd3,4'd1,4'd8} (N*CW bits, slot 0 in LSBs), giving reset coefficients.
REQ-005 clk  in  1  clock; all logic rising-edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  sample offered.
REQ-008 in_data  in  DW  sample, unsigned.
REQ-009 in_ready  out  1  sample accepted when in_valid && in_ready at clk edge.
REQ-010 out_valid  out  1  product held on out_data.
REQ-011 out_ready  in  1  downstream accepts product.
REQ-012 out_data  out  OW  product, unsigned.
REQ-013 out_idx  out  clog2(N)  step index of current product.
REQ-014 out_last  out  1  high with step N-1.
REQ-015 cfg_we  in  1  coefficient write strobe.
REQ-016 cfg_addr  in  clog2(N)  coefficient slot; values >= N ignored.
REQ-017 cfg_data  in  CW  coefficient value, unsigned.

Function
REQ-018 SHALL hold sample register, N-entry coefficient file, step counter, state IDLE/RUN.
REQ-019 in_ready SHALL be combinational: 1 in IDLE; 1 in RUN only when out_valid && out_last && out_ready; else 0.
REQ-020 On accept: sample register <= in_data, state <= RUN, out_idx <= 0, out_data <= in_data*coef[0], out_valid <= 1 at the same edge (1-cycle latency).
REQ-021 Output transfer = out_valid && out_ready; out_data/out_idx/out_last SHALL be stable while out_valid && !out_ready.
REQ-022 On transfer with out_idx = k < N-1: out_idx <= k+1, out_data <= sample*coef[k+1], out_valid stays 1.
REQ-023 On transfer with out_last and no accept same edge: state <= IDLE, out_valid <= 0.
REQ-024 On transfer with out_last and accept same edge: behave as REQ-020 (no bubble); sustained throughput one sample per N cycles.
REQ-025 out_last SHALL equal (out_idx == N-1) && out_valid.
REQ-026 Products SHALL be full-width OW; no truncation or saturation.
REQ-027 cfg write SHALL update coef[cfg_addr] at the clk edge, in any state.
REQ-028 If a write and a product load use the same slot at one edge, product SHALL use the old coefficient.
REQ-029 Write to a slot not yet loaded in current run SHALL affect that run; write to loaded slot SHALL NOT alter held out_data.
REQ-030 in_data while in_ready = 0 SHALL be ignored; no internal buffering beyond one sample.

Reset
REQ-031 While rst = 0: state IDLE, out_valid 0, out_data 0, out_idx 0, sample 0, coef[i] = COEF_INIT slot i; no transfer or write takes effect.
REQ-032 Reset mid-RUN SHALL abandon the sample; first accept after release restarts at step 0.

Verification
REQ-033 Defaults, in_data=5, out_ready=1 -> out_data 40,5,15,35 on consecutive cycles, out_idx 0..3, out_last on 35, then out_valid 0.
REQ-034 in_data=5, out_ready low 3 cycles while out_idx=1 -> out_data holds 5, in_ready 0, then 15,35 resume.
REQ-035 in_valid held, samples 5 then 10, out_ready=1 -> 40,5,15,35,80,10,30,70 with no gap; in_ready high only on last-step cycles.
REQ-036 Idle write cfg_addr=2 cfg_data=15, then in_data=255 -> 2040,255,3825,1785.
REQ-037 During run on step 0, write cfg_addr=3 cfg_data=0 and cfg_addr=4 (ignored) -> step 3 outputs 0, other steps unchanged.
REQ-038 rst low while out_idx=2 -> outputs zero immediately; after release, in_data=1 -> 8,1,3,7.

Source files
------------

// File: rtl/multi_sel_seq.sv
// Sequencer that multiplies one accepted sample by each of N programmable coefficients,
// emitting one full-width product per step under a valid/ready handshake.
module multi_sel_seq #(
    parameter int              DW        = 8,
    parameter int              N         = 4,
    parameter int              CW        = 4,
    parameter logic [N*CW-1:0] COEF_INIT = {4'd7, 4'd3, 4'd1, 4'd8},
    localparam int             OW        = DW + CW,
    localparam int             AW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic [AW-1:0] out_idx,
    output logic          out_last,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [CW-1:0] cfg_data
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] sample;
    logic [CW-1:0] coef [N];
    logic [AW-1:0] next_idx;
    logic          last_step;
    logic          xfer;
    logic          accept;

    function automatic logic [OW-1:0] mul(input logic [DW-1:0] a, input logic [CW-1:0] b);
        return OW'(a) * OW'(b);
    endfunction

    assign next_idx  = out_idx + AW'(1);
    assign last_step = (out_idx == AW'(N - 1));
    assign out_last  = out_valid && last_step;
    assign xfer      = out_valid && out_ready;
    // The next sample may enter on the very edge that retires the last product.
    assign in_ready  = (state == IDLE) || (out_last && out_ready);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (xfer && last_step && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the coefficient file is reset because COEF_INIT is functional
    // state that the datapath relies on, not just a simulation convenience.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) coef[i] <= COEF_INIT[i*CW +: CW];
        end else if (cfg_we && (int'(cfg_addr) < N)) begin
            coef[cfg_addr] <= cfg_data;
        end
    end

    // NOTE: non-blocking updates mean a product loaded on the same edge as a
    // write to its slot reads the coefficient value from before that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample    <= '0;
            out_data  <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            sample    <= in_data;
            out_idx   <= '0;
            out_data  <= mul(in_data, coef[0]);
            out_valid <= 1'b1;
        end else if (xfer) begin
            if (last_step) begin
                out_valid <= 1'b0;
            end else begin
                out_idx  <= next_idx;
                out_data <= mul(sample, coef[next_idx]);
            end
        end
    end

endmodule

// File: tb/tb_multi_sel_seq.sv
// Directed and randomized checks of multi_sel_seq against a product-queue reference model.
module tb_multi_sel_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        out_ready = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [3:0]  cfg_data = '0;

    logic        in_ready, out_valid, out_last;
    logic [11:0] out_data;
    logic [1:0]  out_idx;

    logic        s_in_ready, s_out_valid, s_out_last;
    logic [11:0] s_out_data;
    logic [1:0]  s_out_idx;

    int tests = 0;
    int fails = 0;

    multi_sel_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    // Three-step variant: address 3 is out of range and must be ignored.
    multi_sel_seq #(.N(3), .COEF_INIT(12'h318)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_idx(s_out_idx),
        .out_last(s_out_last), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_seq(input string tag, input int exp [4]);
        for (int k = 0; k < 4; k++) begin
            check({tag, "_valid"}, out_valid, 1);
            check({tag, "_data"}, out_data, exp[k]);
            check({tag, "_idx"}, out_idx, k);
            check({tag, "_last"}, out_last, (k == 3));
            cycle();
        end
        check({tag, "_done"}, out_valid, 0);
    endtask

    initial begin
        int seq035 [8] = '{40, 5, 15, 35, 80, 10, 30, 70};
        int coef_m [4] = '{8, 1, 3, 7};
        int qd [$];
        int qi [$];
        logic exp_ir;

        // Reset state
        cycle(); cycle();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", out_idx, 0);
        check("rst_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b1;
        cycle();

        // Basic run with defaults
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'd5;
        cycle();
        in_valid = 1'b0;
        check_seq("basic", '{40, 5, 15, 35});

        // Backpressure at step 1; offered data while stalled is ignored
        in_valid = 1'b1; in_data = 8'd5;
        cycle();
        check("bp_d0", out_data, 40);
        in_valid = 1'b0;
        cycle();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'd99;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", in_ready, 0);
            cycle();
            check("bp_hold_data", out_data, 5);
            check("bp_hold_idx", out_idx, 1);
            check("bp_hold_valid", out_valid, 1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        check("bp_d2", out_data, 15);
        cycle();
        check("bp_d3", out_data, 35);
        check("bp_last", out_last, 1);
        cycle();
        check("bp_done", out_valid, 0);

        // Back-to-back samples with no bubble
        in_valid = 1'b1; in_data = 8'd5;
        cycle();
        for (int k = 0; k < 8; k++) begin
            check("b2b_data", out_data, seq035[k]);
            check("b2b_idx", out_idx, k % 4);
            #1 check("b2b_in_ready", in_ready, (k % 4) == 3);
            if (k == 0) in_data = 8'd10;
            if (k == 4) in_valid = 1'b0;
            cycle();
        end
        check("b2b_done", out_valid, 0);

        // Idle coefficient write, full-width product
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 4'd15;
        cycle();
        cfg_we = 1'b0; in_valid = 1'b1; in_data = 8'd255;
        cycle();
        in_valid = 1'b0;
        check_seq("wide", '{2040, 255, 3825, 1785});
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 4'd3;
        cycle();
        cfg_we = 1'b0;
        cycle(); cycle(); cycle();

        // Mid-run write to a not-yet-loaded slot; small variant ignores address 3
        in_valid = 1'b1; in_data = 8'd5;
        cycle();
        in_valid = 1'b0;
        check("mid_d0", out_data, 40);
        check("small_d0", s_out_data, 40);
        check("small_v0", s_out_valid, 1);
        cfg_we = 1'b1; cfg_addr = 2'd3; cfg_data = 4'd0;
        cycle();
        cfg_we = 1'b0;
        check("mid_d1", out_data, 5);
        check("small_d1", s_out_data, 5);
        check("small_i1", s_out_idx, 1);
        cycle();
        check("mid_d2", out_data, 15);
        check("small_d2", s_out_data, 15);
        check("small_last", s_out_last, 1);
        cycle();
        check("mid_d3", out_data, 0);
        check("mid_last", out_last, 1);
        check("small_done", s_out_valid, 0);
        cycle();
        check("mid_done", out_valid, 0);

        // Same-edge write uses old coefficient; write to loaded slot leaves held data
        cfg_we = 1'b1; cfg_addr = 2'd3; cfg_data = 4'd7;
        in_valid = 1'b1; in_data = 8'd5;
        cycle();
        in_valid = 1'b0;
        check("old_d0", out_data, 40);
        cfg_addr = 2'd1; cfg_data = 4'd9;
        cycle();
        check("old_coef", out_data, 5);
        cfg_addr = 2'd0; cfg_data = 4'd2; out_ready = 1'b0;
        cycle();
        cfg_we = 1'b0;
        check("held_data", out_data, 5);
        out_ready = 1'b1;
        cycle();
        check("old_d2", out_data, 15);
        cycle();
        check("old_d3", out_data, 35);
        cycle();
        check("old_done", out_valid, 0);

        // Reset mid-run abandons the sample and restores coefficients
        in_valid = 1'b1; in_data = 8'd5;
        cycle();
        in_valid = 1'b0;
        check("pre_d0", out_data, 10);
        cycle();
        check("pre_d1", out_data, 45);
        cycle();
        check("pre_d2", out_data, 15);
        check("pre_i2", out_idx, 2);
        rst = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_idx", out_idx, 0);
        check("arst_last", out_last, 0);
        cycle();
        rst = 1'b1;
        in_valid = 1'b1; in_data = 8'd1;
        cycle();
        in_valid = 1'b0;
        check_seq("after_rst", '{8, 1, 3, 7});

        // Randomized handshake traffic against a queue of expected products
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ir = (qd.size() == 0) || (qd.size() == 1 && out_ready);
            check("rnd_in_ready", in_ready, exp_ir);
            check("rnd_valid", out_valid, qd.size() > 0);
            if (qd.size() > 0) begin
                check("rnd_data", out_data, qd[0]);
                check("rnd_idx", out_idx, qi[0]);
                check("rnd_last", out_last, qi[0] == 3);
                if (out_ready) begin
                    void'(qd.pop_front());
                    void'(qi.pop_front());
                end
            end
            if (in_valid && exp_ir) begin
                for (int k = 0; k < 4; k++) begin
                    qd.push_back(int'(in_data) * coef_m[k]);
                    qi.push_back(k);
                end
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
